inst_fetch_bridge: RTL and testbench

INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

---
 rtl/inst_fetch_bridge.sv | 118 +++++++++++
 tb/tb_inst_fetch_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: a one-entry line buffer in front of a request/ack
// backing memory, with stall generation, flush handling and a fetch timeout.
module inst_fetch_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_WORD       = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rom_chip_enable,
  input  logic [31:0] rom_address_input,
  output logic [31:0] rom_data_output,
  output logic        stop_all_req_from_if,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_address,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        fetch_error
);

  localparam logic       STATE_IDLE = 1'b0;
  localparam logic       STATE_WAIT = 1'b1;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);

  logic        state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fetch_error_q, fetch_error_d;
  logic        flush_pend_q, flush_pend_d;
  logic        hit;

  // Byte offset bits are deliberately ignored when matching the tag.
  assign hit = rom_chip_enable && buf_valid_q &&
               (buf_tag_q == rom_address_input[31:2]);

  assign rom_data_output      = hit ? buf_data_q : NOP_WORD;
  assign stop_all_req_from_if = rom_chip_enable && !hit;
  assign mem_req              = mem_req_q;
  assign mem_address          = mem_address_q;
  assign fetch_error          = fetch_error_q;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_address_d = mem_address_q;
    buf_valid_d   = buf_valid_q;
    buf_tag_d     = buf_tag_q;
    buf_data_d    = buf_data_q;
    cnt_d         = cnt_q;
    fetch_error_d = fetch_error_q;
    flush_pend_d  = flush_pend_q;

    case (state_q)
      STATE_IDLE: begin
        if (flush) begin
          buf_valid_d = 1'b0;
        end
        if (rom_chip_enable && !hit) begin
          mem_req_d     = 1'b1;
          mem_address_d = rom_address_input & 32'hFFFF_FFFC;
          cnt_d         = 8'd0;
          state_d       = STATE_WAIT;
        end
      end
      default: begin
        // A flush seen while waiting is remembered and applied to the fill.
        flush_pend_d = flush_pend_q | flush;
        if (mem_ack) begin
          buf_data_d   = mem_data;
          buf_tag_d    = mem_address_q[31:2];
          buf_valid_d  = !(flush_pend_q || flush);
          flush_pend_d = 1'b0;
          mem_req_d    = 1'b0;
          state_d      = STATE_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          buf_data_d    = NOP_WORD;
          buf_tag_d     = mem_address_q[31:2];
          buf_valid_d   = !(flush_pend_q || flush);
          flush_pend_d  = 1'b0;
          fetch_error_d = 1'b1;
          mem_req_d     = 1'b0;
          state_d       = STATE_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= STATE_IDLE;
      mem_req_q     <= 1'b0;
      mem_address_q <= 32'd0;
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= 30'd0;
      buf_data_q    <= 32'd0;
      cnt_q         <= 8'd0;
      fetch_error_q <= 1'b0;
      flush_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_address_q <= mem_address_d;
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
      cnt_q         <= cnt_d;
      fetch_error_q <= fetch_error_d;
      flush_pend_q  <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: expected request addresses and
// fill data are queued as stimulus is driven and popped when the DUT responds.
module tb_inst_fetch_bridge;

  logic        clock;
  logic        reset;
  logic        rom_chip_enable;
  logic [31:0] rom_address_input;
  logic [31:0] rom_data_output;
  logic        stop_all_req_from_if;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_address;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        fetch_error;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  inst_fetch_bridge #(
    .TIMEOUT_CYCLES(4),
    .NOP_WORD(32'h00000000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rom_chip_enable(rom_chip_enable),
    .rom_address_input(rom_address_input),
    .rom_data_output(rom_data_output),
    .stop_all_req_from_if(stop_all_req_from_if),
    .flush(flush),
    .mem_req(mem_req),
    .mem_address(mem_address),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .fetch_error(fetch_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic [31:0] addr,
                               input logic fl, input logic ack,
                               input logic [31:0] data);
    rom_chip_enable   = ce;
    rom_address_input = addr;
    flush             = fl;
    mem_ack           = ack;
    mem_data          = data;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Wait (bounded) for a request and compare it with the oldest expected address.
  task automatic waitRequest(input string tag);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!mem_req && n < 5) begin
      tick();
      n++;
    end
    checkOutput({tag, "_req"}, {31'd0, mem_req}, 32'd1);
    exp = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
    checkOutput({tag, "_addr"}, mem_address, exp);
  endtask

  task automatic checkFill(input string tag);
    logic [31:0] exp;
    exp = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 32'hFFFF_FFFF;
    checkOutput({tag, "_stall"}, {31'd0, stop_all_req_from_if}, 32'd0);
    checkOutput({tag, "_data"}, rom_data_output, exp);
  endtask

  initial begin
    int n;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_addr", mem_address, 32'd0);
    checkOutput("rst_err", {31'd0, fetch_error}, 32'd0);
    reset = 1'b0;

    // Cold miss on 0x4, ack one cycle after the request.
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    checkOutput("cold_stall0", {31'd0, stop_all_req_from_if}, 32'd1);
    checkOutput("cold_nop", rom_data_output, 32'd0);
    exp_addr_q.push_back(32'h4);
    tick();
    checkOutput("cold_stall1", {31'd0, stop_all_req_from_if}, 32'd1);
    waitRequest("cold");
    exp_data_q.push_back(32'h34011100);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b1, 32'h34011100);
    tick();
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
    checkFill("cold");
    checkOutput("cold_req_drop", {31'd0, mem_req}, 32'd0);

    // Hit reuse with different byte offset.
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0, 32'h0);
    checkOutput("hit_stall", {31'd0, stop_all_req_from_if}, 32'd0);
    checkOutput("hit_data", rom_data_output, 32'h34011100);
    tick();
    checkOutput("hit_noreq", {31'd0, mem_req}, 32'd0);

    // Stray ack in IDLE is ignored.
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b1, 32'hCAFEF00D);
    tick();
    applyStimulus(1'b1, 32'h6, 1'b0, 1'b0, 32'h0);
    checkOutput("idle_ack_data", rom_data_output, 32'h34011100);
    checkOutput("idle_ack_req", {31'd0, mem_req}, 32'd0);

    // Chip enable low with a miss address.
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0, 32'h0);
    checkOutput("ce0_stall", {31'd0, stop_all_req_from_if}, 32'd0);
    checkOutput("ce0_data", rom_data_output, 32'd0);
    tick();
    checkOutput("ce0_req", {31'd0, mem_req}, 32'd0);

    // Address changes while waiting; completion fills the requested tag only.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    exp_addr_q.push_back(32'h10);
    tick();
    waitRequest("mis1");
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("mis_hold_addr", mem_address, 32'h10);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 32'hAAAA5555);
    tick();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
    checkOutput("mis_stall", {31'd0, stop_all_req_from_if}, 32'd1);
    exp_addr_q.push_back(32'h20);
    tick();
    waitRequest("mis2");
    exp_data_q.push_back(32'h12345678);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 32'h12345678);
    tick();
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
    checkFill("mis2");

    // Flush during WAIT is remembered and invalidates the fill.
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
    exp_addr_q.push_back(32'h30);
    tick();
    waitRequest("fw1");
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b1, 32'hBEEF0001);
    tick();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
    checkOutput("fw_stall", {31'd0, stop_all_req_from_if}, 32'd1);
    checkOutput("fw_nop", rom_data_output, 32'd0);
    exp_addr_q.push_back(32'h30);
    tick();
    waitRequest("fw2");
    exp_data_q.push_back(32'hBEEF0002);
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b1, 32'hBEEF0002);
    tick();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
    checkFill("fw2");

    // Flush in IDLE: current cycle still hits, next cycle misses.
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h0);
    checkOutput("fi_hit", rom_data_output, 32'hBEEF0002);
    tick();
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
    checkOutput("fi_stall", {31'd0, stop_all_req_from_if}, 32'd1);
    exp_addr_q.push_back(32'h30);
    tick();
    waitRequest("fi");
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b1, 32'h0);
    tick();

    // Flush coincident with ack: buffer stays invalid, same address re-requested.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    exp_addr_q.push_back(32'h40);
    tick();
    waitRequest("fa1");
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 32'h55550000);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    checkOutput("fa_stall", {31'd0, stop_all_req_from_if}, 32'd1);
    exp_addr_q.push_back(32'h40);
    tick();
    waitRequest("fa2");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    tick();

    // Timeout: no ack, request held for 4 cycles, then NOP hit with error.
    applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 32'h0);
    exp_addr_q.push_back(32'h50);
    tick();
    waitRequest("to");
    n = 0;
    while (mem_req && n < 20) begin
      tick();
      n++;
    end
    checkOutput("to_cycles", n, 32'd4);
    checkOutput("to_err", {31'd0, fetch_error}, 32'd1);
    checkOutput("to_stall", {31'd0, stop_all_req_from_if}, 32'd0);
    checkOutput("to_data", rom_data_output, 32'd0);
    applyStimulus(1'b0, 32'h50, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("to_err_sticky", {31'd0, fetch_error}, 32'd1);

    // Reset mid-WAIT, then a late ack.
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0);
    exp_addr_q.push_back(32'h60);
    tick();
    waitRequest("rw");
    applyStimulus(1'b0, 32'h60, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rw_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1'b0, 32'h60, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0);
    checkOutput("rw_req_late", {31'd0, mem_req}, 32'd0);
    checkOutput("rw_err", {31'd0, fetch_error}, 32'd0);
    checkOutput("rw_stall", {31'd0, stop_all_req_from_if}, 32'd1);
    checkOutput("rw_nop", rom_data_output, 32'd0);
    checkOutput("sb_empty", exp_addr_q.size() + exp_data_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
